// File: rtl/modexp_word_port.sv
`default_nettype none
// ============================================================================
// Module   : modexp_word_port
// Purpose  : Device-side end of the word-serial ModExp host interface.
//            Assembles five wide operands (m, e, n, r, t) from DATA_WIDTH-bit
//            words sent LSW first, latches nprime0 with word 0, then pulses
//            core_start. After the core reports completion, it streams the
//            wide result back one word per cycle when the host requests it.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   startInput          : host request to begin an operand load (IDLE only)
//   m/e/n/r/t_buf       : operand words, one per cycle during LOAD
//   nprime0             : -n^-1 mod 2^64, sampled together with word 0
//   getResult           : host request to read the result (RES_READY only)
//   core_done           : core pulse, result valid (WAIT_CORE only)
//   core_result         : full-width result from the core
//   m/e/n/r/t_out       : assembled operands
//   np0_out             : latched nprime0
//   core_start          : one-cycle pulse once all operand words are stored
//   res_out, res_valid  : result word stream, LSW first
//   read_done           : one-cycle pulse after the last result word
//   state               : current FSM state encoding
// ============================================================================
module modexp_word_port #(
  parameter int DATA_WIDTH = 64,
  parameter int WORDS      = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startInput,
  input  logic [DATA_WIDTH-1:0]       m_buf,
  input  logic [DATA_WIDTH-1:0]       e_buf,
  input  logic [DATA_WIDTH-1:0]       n_buf,
  input  logic [DATA_WIDTH-1:0]       r_buf,
  input  logic [DATA_WIDTH-1:0]       t_buf,
  input  logic [63:0]                 nprime0,
  input  logic                        getResult,
  input  logic                        core_done,
  input  logic [DATA_WIDTH*WORDS-1:0] core_result,
  output logic [DATA_WIDTH*WORDS-1:0] m_out,
  output logic [DATA_WIDTH*WORDS-1:0] e_out,
  output logic [DATA_WIDTH*WORDS-1:0] n_out,
  output logic [DATA_WIDTH*WORDS-1:0] r_out,
  output logic [DATA_WIDTH*WORDS-1:0] t_out,
  output logic [63:0]                 np0_out,
  output logic                        core_start,
  output logic [DATA_WIDTH-1:0]       res_out,
  output logic                        res_valid,
  output logic                        read_done,
  output logic [3:0]                  state
);

  localparam int OPW  = DATA_WIDTH * WORDS;
  localparam int IDXW = $clog2(OPW);
  localparam logic [6:0] CNT_LAST = 7'(WORDS - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ARM       = 4'd1,
    LOAD      = 4'd2,
    WAIT_CORE = 4'd3,
    RES_READY = 4'd4,
    SEND      = 4'd5,
    FINISH    = 4'd6
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              core_start_q, core_start_d;
  logic              res_valid_q, res_valid_d;
  logic              read_done_q, read_done_d;
  logic [OPW-1:0]    m_q, e_q, n_q, r_q, t_q, result_q;
  logic [63:0]       np0_q;
  logic [DATA_WIDTH-1:0] res_out_q;
  logic [IDXW-1:0]   slice_base;

  // Bit offset of the word addressed by the shared load/send counter.
  assign slice_base = IDXW'(cnt_q) * IDXW'(DATA_WIDTH);

  // --------------------------------------------------------------------------
  // Next-state and pulse logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_start_d = 1'b0;
    res_valid_d  = 1'b0;
    read_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (startInput) state_d = ARM;
      end
      ARM: begin
        // Dead cycle covering the host's registered output buffers.
        state_d = LOAD;
        cnt_d   = 7'd0;
      end
      LOAD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d        = 7'd0;
          core_start_d = 1'b1;
          state_d      = WAIT_CORE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      WAIT_CORE: begin
        // getResult here is deliberately ignored, even alongside core_done.
        if (core_done) state_d = RES_READY;
      end
      RES_READY: begin
        if (getResult) begin
          state_d = SEND;
          cnt_d   = 7'd0;
        end
      end
      SEND: begin
        res_valid_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 7'd0;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      FINISH: begin
        read_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 7'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and registered pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 7'd0;
      core_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      read_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      res_valid_q  <= res_valid_d;
      read_done_q  <= read_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Operand assembly, result capture and result word output
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q       <= '0;
      e_q       <= '0;
      n_q       <= '0;
      r_q       <= '0;
      t_q       <= '0;
      np0_q     <= '0;
      result_q  <= '0;
      res_out_q <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          m_q[slice_base +: DATA_WIDTH] <= m_buf;
          e_q[slice_base +: DATA_WIDTH] <= e_buf;
          n_q[slice_base +: DATA_WIDTH] <= n_buf;
          r_q[slice_base +: DATA_WIDTH] <= r_buf;
          t_q[slice_base +: DATA_WIDTH] <= t_buf;
          if (cnt_q == 7'd0) np0_q <= nprime0;
        end
        WAIT_CORE: begin
          if (core_done) result_q <= core_result;
        end
        SEND: begin
          res_out_q <= result_q[slice_base +: DATA_WIDTH];
        end
        default: begin
        end
      endcase
    end
  end

  assign m_out      = m_q;
  assign e_out      = e_q;
  assign n_out      = n_q;
  assign r_out      = r_q;
  assign t_out      = t_q;
  assign np0_out    = np0_q;
  assign core_start = core_start_q;
  assign res_out    = res_out_q;
  assign res_valid  = res_valid_q;
  assign read_done  = read_done_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_modexp_word_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_modexp_word_port
// Purpose  : Self-checking bench for modexp_word_port. Operand and result
//            contents are held as plain word arrays; expected timing follows
//            the host-visible cycle rules of the interface.
// Revision : 1.0  initial release
// ============================================================================
module tb_modexp_word_port;

  localparam int DW  = 64;
  localparam int NW  = 64;
  localparam int OPW = DW * NW;

  logic           clk = 1'b0;
  logic           reset, startInput, getResult, core_done;
  logic [DW-1:0]  m_buf, e_buf, n_buf, r_buf, t_buf;
  logic [63:0]    nprime0;
  logic [OPW-1:0] core_result;
  logic [OPW-1:0] m_out, e_out, n_out, r_out, t_out;
  logic [63:0]    np0_out;
  logic           core_start, res_valid, read_done;
  logic [DW-1:0]  res_out;
  logic [3:0]     state;

  always #5 clk = ~clk;

  modexp_word_port #(.DATA_WIDTH(DW), .WORDS(NW)) dut (
    .clk(clk), .reset(reset), .startInput(startInput),
    .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
    .nprime0(nprime0), .getResult(getResult), .core_done(core_done),
    .core_result(core_result),
    .m_out(m_out), .e_out(e_out), .n_out(n_out), .r_out(r_out), .t_out(t_out),
    .np0_out(np0_out), .core_start(core_start), .res_out(res_out),
    .res_valid(res_valid), .read_done(read_done), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // Reference contents: op_w[0..4] = m,e,n,r,t words; res_w = result words.
  logic [63:0] op_w [5][NW];
  logic [63:0] res_w [NW];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] dut_word(input int op, input int k);
    logic [OPW-1:0] v;
    case (op)
      0:       v = m_out;
      1:       v = e_out;
      2:       v = n_out;
      3:       v = r_out;
      default: v = t_out;
    endcase
    return 64'(v >> (k * DW));
  endfunction

  task automatic set_bus(input int k);
    m_buf = op_w[0][k];
    e_buf = op_w[1][k];
    n_buf = op_w[2][k];
    r_buf = op_w[3][k];
    t_buf = op_w[4][k];
  endtask

  task automatic fill_ops_random;
    for (int op = 0; op < 5; op++)
      for (int k = 0; k < NW; k++) op_w[op][k] = {$urandom, $urandom};
  endtask

  // Full operand load. hold keeps startInput high throughout; stray_done
  // pulses core_done in the middle of the load.
  task automatic run_load(input bit hold, input bit stray_done,
                          input logic [63:0] np, input string tag);
    int cs_pulses = 0;
    int bad_state = 0;
    startInput = 1'b1;
    tick;
    chk({tag, "_arm"}, 64'(state), 64'd1);
    if (!hold) startInput = 1'b0;
    tick;
    chk({tag, "_load_entry"}, 64'(state), 64'd2);
    for (int k = 0; k < NW; k++) begin
      set_bus(k);
      nprime0   = (k == 0) ? np : {$urandom, $urandom};
      core_done = stray_done && (k == 20);
      tick;
      if (core_start) cs_pulses++;
      if (k < NW - 1 && state !== 4'd2) bad_state++;
      if (k == NW - 1) chk({tag, "_start_at_last"}, 64'(core_start), 64'd1);
    end
    core_done  = 1'b0;
    startInput = 1'b0;
    chk({tag, "_load_state"}, 64'(bad_state), 64'd0);
    chk({tag, "_wait_core"}, 64'(state), 64'd3);
    tick;
    if (core_start) cs_pulses++;
    chk({tag, "_start_pulses"}, 64'(cs_pulses), 64'd1);
    chk({tag, "_still_wait"}, 64'(state), 64'd3);
    for (int op = 0; op < 5; op++)
      for (int k = 0; k < NW; k++)
        chk($sformatf("%s_op%0d_w%0d", tag, op, k), dut_word(op, k), op_w[op][k]);
    chk({tag, "_np0"}, np0_out, np);
  endtask

  task automatic finish_core(input bit with_get, input string tag);
    logic [OPW-1:0] cr = '0;
    for (int k = NW - 1; k >= 0; k--) cr = (cr << DW) | OPW'(res_w[k]);
    core_result = cr;
    core_done   = 1'b1;
    getResult   = with_get;
    tick;
    core_done   = 1'b0;
    getResult   = 1'b0;
    core_result = {OPW/32{$urandom}};
    chk({tag, "_res_ready"}, 64'(state), 64'd4);
    chk({tag, "_no_valid"}, 64'(res_valid), 64'd0);
    repeat (5) tick;
    chk({tag, "_res_ready_hold"}, 64'(state), 64'd4);
    chk({tag, "_no_valid_hold"}, 64'(res_valid), 64'd0);
  endtask

  task automatic read_result(input string tag);
    getResult = 1'b1;
    tick;
    getResult = 1'b0;
    chk({tag, "_send"}, 64'(state), 64'd5);
    chk({tag, "_valid_pre"}, 64'(res_valid), 64'd0);
    for (int k = 0; k < NW; k++) begin
      tick;
      chk($sformatf("%s_valid_w%0d", tag, k), 64'(res_valid), 64'd1);
      chk($sformatf("%s_res_w%0d", tag, k), res_out, res_w[k]);
    end
    tick;
    chk({tag, "_valid_end"}, 64'(res_valid), 64'd0);
    chk({tag, "_read_done"}, 64'(read_done), 64'd1);
    chk({tag, "_idle"}, 64'(state), 64'd0);
    tick;
    chk({tag, "_read_done_once"}, 64'(read_done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int x;
    int cs_cnt;
    reset = 1'b1; startInput = 1'b0; getResult = 1'b0; core_done = 1'b0;
    m_buf = '0; e_buf = '0; n_buf = '0; r_buf = '0; t_buf = '0;
    nprime0 = '0; core_result = '0;
    tick; tick;
    reset = 1'b0;

    // Reset values
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_ops", 64'(|{m_out, e_out, n_out, r_out, t_out}), 64'd0);
    chk("rst_np0", np0_out, 64'd0);
    chk("rst_res_out", res_out, 64'd0);
    chk("rst_pulses", 64'({core_start, res_valid, read_done}), 64'd0);

    // Small-value load: m=8, e=13, n=77, r=R mod 77, t=R^2 mod 77
    x = 1;
    repeat (OPW) x = (x * 2) % 77;
    for (int op = 0; op < 5; op++)
      for (int k = 0; k < NW; k++) op_w[op][k] = '0;
    op_w[0][0] = 64'd8;
    op_w[1][0] = 64'd13;
    op_w[2][0] = 64'd77;
    op_w[3][0] = 64'(x);
    op_w[4][0] = 64'((x * x) % 77);
    run_load(1'b0, 1'b0, 64'd1, "small");

    // Result k*3, read after a 5-cycle delay
    for (int k = 0; k < NW; k++) res_w[k] = 64'(k * 3);
    finish_core(1'b0, "r3");
    read_result("r3");

    // Indexed pattern on every bus, then getResult coinciding with core_done
    for (int op = 0; op < 5; op++)
      for (int k = 0; k < NW; k++) op_w[op][k] = {32'hA5A5_0000 + 32'(k), 32'(k)};
    run_load(1'b0, 1'b0, {$urandom, $urandom}, "pat");
    for (int k = 0; k < NW; k++) res_w[k] = {$urandom, $urandom};
    finish_core(1'b1, "coinc");
    read_result("coinc");

    // Random operands, startInput held high, stray core_done during LOAD
    fill_ops_random();
    run_load(1'b1, 1'b1, {$urandom, $urandom}, "hold");
    for (int k = 0; k < NW; k++) res_w[k] = {$urandom, $urandom};
    finish_core(1'b0, "rnd");
    read_result("rnd");

    // Stray getResult / core_done while idle
    getResult = 1'b1; core_done = 1'b1;
    tick;
    getResult = 1'b0; core_done = 1'b0;
    chk("idle_ignore", 64'(state), 64'd0);
    chk("idle_no_valid", 64'(res_valid), 64'd0);

    // Reset in the middle of a load (cnt = 30)
    fill_ops_random();
    startInput = 1'b1;
    tick;
    startInput = 1'b0;
    tick;
    for (int k = 0; k < 30; k++) begin
      set_bus(k);
      tick;
    end
    chk("midrst_in_load", 64'(state), 64'd2);
    reset = 1'b1;
    set_bus(30);
    tick;
    reset = 1'b0;
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_m_w0", dut_word(0, 0), 64'd0);
    chk("midrst_ops", 64'(|{m_out, e_out, n_out, r_out, t_out}), 64'd0);
    cs_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      tick;
      if (core_start) cs_cnt++;
    end
    chk("midrst_no_start", 64'(cs_cnt), 64'd0);
    chk("midrst_idle", 64'(state), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
